// File: rtl/disp_value_sel.sv
// disp_value_sel: picks one of four 32-bit observation values, windows and
// saturates/truncates it to 13 bits, and presents it to the 7-segment driver.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-low reset
//   src0..src3 in   32  observation values (PC, instr, ALU out, WB data)
//   sel        in   2   source select switches (asynchronous)
//   btn_hold   in   1   raw pushbutton, toggles freeze
//   btn_shift  in   1   raw pushbutton, advances the 13-bit window
//   num        out  13  value to the display driver
//   win        out  2   current window index (0,1,2)
//   hold_led   out  1   1 while frozen
//   ovf        out  1   1 when num is not the exact window content
module disp_value_sel #(
    parameter int DB_BITS  = 20,
    parameter int UPD_BITS = 22,
    parameter bit SAT      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    input  logic [1:0]  sel,
    input  logic        btn_hold,
    input  logic        btn_shift,
    output logic [12:0] num,
    output logic [1:0]  win,
    output logic        hold_led,
    output logic        ovf
);
    typedef enum logic {RUN, HOLD} state_e;
    state_e state_q, state_d;
    logic [1:0]              sel_s1_q, sel_s2_q;
    // button index 0 = hold, 1 = shift
    logic [1:0]              btn_s1_q, btn_s2_q, stable_q, stable_d, pulse_q;
    logic [1:0][DB_BITS-1:0] cnt_q, cnt_d;
    logic [UPD_BITS-1:0]     upd_q;
    logic [1:0]              win_q, win_d;
    logic                    force_q, force_d;
    logic [12:0]             num_q, num_d;
    logic                    ovf_q, ovf_d;
    logic [31:0]             src_sel, shifted;
    logic                    hold_p, shift_p, tick, load, win_ovf;
    assign hold_p  = pulse_q[0];
    assign shift_p = pulse_q[1];
    assign tick    = upd_q == '0;
    // Debounce: an input differing from the stable state must persist until
    // the counter reaches all-ones before it is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
            if (btn_s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (&cnt_q[i]) begin
                stable_d[i] = btn_s2_q[i];
                cnt_d[i]    = '0;
            end
        end
    end
    assign src_sel = sel_s2_q == 2'd0 ? src0 :
                     sel_s2_q == 2'd1 ? src1 :
                     sel_s2_q == 2'd2 ? src2 : src3;
    assign shifted = win_q == 2'd1 ? src_sel >> 13 :
                     win_q == 2'd2 ? src_sel >> 26 : src_sel;
    assign win_ovf = |shifted[31:13];
    assign win_d   = shift_p ? (win_q == 2'd2 ? 2'd0 : win_q + 2'd1) : win_q;
    always_comb begin
        state_d = state_q;
        force_d = (sel_s1_q != sel_s2_q) || (win_d != win_q);
        load    = 1'b0;
        if (state_q == RUN) begin
            // A tick coinciding with the freeze pulse still loads this cycle.
            load = tick || force_q;
            if (hold_p) state_d = HOLD;
        end else if (hold_p) begin
            state_d = RUN;
            force_d = 1'b1;
        end
        num_d = load ? (win_ovf && SAT ? 13'h1FFF : shifted[12:0]) : num_q;
        ovf_d = load ? win_ovf : ovf_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            sel_s1_q <= '0;
            sel_s2_q <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            pulse_q  <= '0;
            upd_q    <= '0;
            win_q    <= '0;
            force_q  <= 1'b0;
            num_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_s1_q <= sel;
            sel_s2_q <= sel_s1_q;
            btn_s1_q <= {btn_shift, btn_hold};
            btn_s2_q <= btn_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= stable_d & ~stable_q;
            upd_q    <= upd_q + 1'b1;
            win_q    <= win_d;
            force_q  <= force_d;
            num_q    <= num_d;
            ovf_q    <= ovf_d;
        end
    end
    assign num      = num_q;
    assign win      = win_q;
    assign ovf      = ovf_q;
    assign hold_led = state_q == HOLD;
endmodule
